// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard/sequencing controller
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_J   = 2'd2;
    localparam logic [1:0] PCSRC_JR  = 2'd3;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // JR outranks J/JAL, which outrank a conditional branch.
    function automatic logic [1:0] redirect_src(input logic jr, input logic jmp);
        if (jr) begin
            return PCSRC_JR;
        end else if (jmp) begin
            return PCSRC_J;
        end else begin
            return PCSRC_BR;
        end
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and taken-control-transfer detection
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_WriteReg,
    input  logic       BEQ_EX_MEM,
    input  logic       BNE_EX_MEM,
    input  logic       Zero_EX_MEM,
    input  logic       J_EX_MEM,
    input  logic       JAL_EX_MEM,
    input  logic       JR_EX_MEM,
    output logic       load_use,
    output logic       take
);

    logic src_match;

    always_comb begin
        src_match = (ID_EX_WriteReg == IF_ID_Rs) | (ID_EX_WriteReg == IF_ID_Rt);
        // A load into $zero never produces a value worth waiting for.
        load_use  = ID_EX_MemRead & (ID_EX_WriteReg != ZERO_REG) & src_match;
        take      = (BEQ_EX_MEM & Zero_EX_MEM) | (BNE_EX_MEM & ~Zero_EX_MEM)
                  | J_EX_MEM | JAL_EX_MEM | JR_EX_MEM;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline stall/flush/next-PC controller with memory wait and perf counters
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_WriteReg,
    input  logic             BEQ_EX_MEM,
    input  logic             BNE_EX_MEM,
    input  logic             Zero_EX_MEM,
    input  logic             J_EX_MEM,
    input  logic             JAL_EX_MEM,
    input  logic             JR_EX_MEM,
    input  logic             MemRead_EX_MEM,
    input  logic             MemWrite_EX_MEM,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PC_Enable,
    output logic             Enable_IF_ID,
    output logic             Enable_ID_EX,
    output logic             Enable_EX_MEM,
    output logic             Enable_MEM_WB,
    output logic             Flush_IF_ID,
    output logic             Flush_ID_EX,
    output logic             Flush_EX_MEM,
    output logic [1:0]       PCSrc,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    logic load_use;
    logic take;
    logic mem_op;
    logic timeout;
    logic advance;
    logic redirect;
    logic lu_stall;
    logic stall_inc;

    hazard_detect u_hazard (
        .IF_ID_Rs       (IF_ID_Rs),
        .IF_ID_Rt       (IF_ID_Rt),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_WriteReg (ID_EX_WriteReg),
        .BEQ_EX_MEM     (BEQ_EX_MEM),
        .BNE_EX_MEM     (BNE_EX_MEM),
        .Zero_EX_MEM    (Zero_EX_MEM),
        .J_EX_MEM       (J_EX_MEM),
        .JAL_EX_MEM     (JAL_EX_MEM),
        .JR_EX_MEM      (JR_EX_MEM),
        .load_use       (load_use),
        .take           (take)
    );

    // advance marks cycles in which EX_MEM moves on; a pending redirect only fires then.
    always_comb begin
        mem_op  = MemRead_EX_MEM | MemWrite_EX_MEM;
        timeout = (state == MEM_WAIT) & ~mem_ready & (wait_cnt == WAIT_W'(MEM_TIMEOUT));
        if (state == RUN) begin
            advance = ~mem_op | mem_ready;
        end else begin
            advance = mem_ready | timeout;
        end
        redirect  = advance & take;
        lu_stall  = advance & ~take & load_use;
        stall_inc = (state == MEM_WAIT) | lu_stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_op & ~mem_ready) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready | timeout) begin
                    state_next = RUN;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        PC_Enable     = 1'b0;
        Enable_IF_ID  = 1'b0;
        Enable_ID_EX  = 1'b0;
        Enable_EX_MEM = 1'b0;
        Enable_MEM_WB = 1'b0;
        Flush_IF_ID   = 1'b0;
        Flush_ID_EX   = 1'b0;
        Flush_EX_MEM  = 1'b0;
        PCSrc         = PCSRC_SEQ;
        if (!reset) begin
            mem_req = (state == MEM_WAIT) | mem_op;
            if (advance) begin
                PC_Enable     = 1'b1;
                Enable_IF_ID  = 1'b1;
                Enable_ID_EX  = 1'b1;
                Enable_EX_MEM = 1'b1;
                Enable_MEM_WB = 1'b1;
                if (redirect) begin
                    Flush_IF_ID  = 1'b1;
                    Flush_ID_EX  = 1'b1;
                    Flush_EX_MEM = 1'b1;
                    PCSrc        = redirect_src(JR_EX_MEM, J_EX_MEM | JAL_EX_MEM);
                end else if (lu_stall) begin
                    PC_Enable    = 1'b0;
                    Enable_IF_ID = 1'b0;
                    Flush_ID_EX  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_error   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (timeout) begin
                mem_error <= 1'b1;
            end
            if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (redirect && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_WriteReg;
    logic        ID_EX_MemRead;
    logic        BEQ_EX_MEM, BNE_EX_MEM, Zero_EX_MEM, J_EX_MEM, JAL_EX_MEM, JR_EX_MEM;
    logic        MemRead_EX_MEM, MemWrite_EX_MEM, mem_ready;

    logic        mem_req, PC_Enable, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB;
    logic        Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, mem_error;
    logic [1:0]  PCSrc;
    logic [15:0] stall_count, flush_count;

    logic        s_mem_req, s_PC_Enable, s_Enable_IF_ID, s_Enable_ID_EX, s_Enable_EX_MEM, s_Enable_MEM_WB;
    logic        s_Flush_IF_ID, s_Flush_ID_EX, s_Flush_EX_MEM, s_mem_error;
    logic [1:0]  s_PCSrc;
    logic [1:0]  s_stall_count, s_flush_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall;
    int exp_flush;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_WriteReg(ID_EX_WriteReg),
        .BEQ_EX_MEM(BEQ_EX_MEM), .BNE_EX_MEM(BNE_EX_MEM), .Zero_EX_MEM(Zero_EX_MEM),
        .J_EX_MEM(J_EX_MEM), .JAL_EX_MEM(JAL_EX_MEM), .JR_EX_MEM(JR_EX_MEM),
        .MemRead_EX_MEM(MemRead_EX_MEM), .MemWrite_EX_MEM(MemWrite_EX_MEM),
        .mem_ready(mem_ready), .mem_req(mem_req),
        .PC_Enable(PC_Enable), .Enable_IF_ID(Enable_IF_ID), .Enable_ID_EX(Enable_ID_EX),
        .Enable_EX_MEM(Enable_EX_MEM), .Enable_MEM_WB(Enable_MEM_WB),
        .Flush_IF_ID(Flush_IF_ID), .Flush_ID_EX(Flush_ID_EX), .Flush_EX_MEM(Flush_EX_MEM),
        .PCSrc(PCSrc), .mem_error(mem_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow counters and short timeout to reach the saturation and abort boundaries quickly.
    pipeline_ctrl #(.MEM_TIMEOUT(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_WriteReg(ID_EX_WriteReg),
        .BEQ_EX_MEM(BEQ_EX_MEM), .BNE_EX_MEM(BNE_EX_MEM), .Zero_EX_MEM(Zero_EX_MEM),
        .J_EX_MEM(J_EX_MEM), .JAL_EX_MEM(JAL_EX_MEM), .JR_EX_MEM(JR_EX_MEM),
        .MemRead_EX_MEM(MemRead_EX_MEM), .MemWrite_EX_MEM(MemWrite_EX_MEM),
        .mem_ready(mem_ready), .mem_req(s_mem_req),
        .PC_Enable(s_PC_Enable), .Enable_IF_ID(s_Enable_IF_ID), .Enable_ID_EX(s_Enable_ID_EX),
        .Enable_EX_MEM(s_Enable_EX_MEM), .Enable_MEM_WB(s_Enable_MEM_WB),
        .Flush_IF_ID(s_Flush_IF_ID), .Flush_ID_EX(s_Flush_ID_EX), .Flush_EX_MEM(s_Flush_EX_MEM),
        .PCSrc(s_PCSrc), .mem_error(s_mem_error),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; ID_EX_MemRead = 1'b0; ID_EX_WriteReg = 5'd0;
        BEQ_EX_MEM = 1'b0; BNE_EX_MEM = 1'b0; Zero_EX_MEM = 1'b0;
        J_EX_MEM = 1'b0; JAL_EX_MEM = 1'b0; JR_EX_MEM = 1'b0;
        MemRead_EX_MEM = 1'b0; MemWrite_EX_MEM = 1'b0; mem_ready = 1'b0;
    endtask

    // Packs {mem_req, 5 enables, 3 flushes, PCSrc} into one word for compact checks.
    function automatic logic [10:0] ctl();
        return {mem_req, PC_Enable, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB,
                Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, PCSrc};
    endfunction

    localparam logic [10:0] CTL_RUN    = 11'b0_11111_000_00;
    localparam logic [10:0] CTL_OFF    = 11'b0_00000_000_00;
    localparam logic [10:0] CTL_LU     = 11'b0_00111_010_00;
    localparam logic [10:0] CTL_BR     = 11'b0_11111_111_01;
    localparam logic [10:0] CTL_J      = 11'b0_11111_111_10;
    localparam logic [10:0] CTL_JR     = 11'b0_11111_111_11;
    localparam logic [10:0] CTL_FREEZE = 11'b1_00000_000_00;
    localparam logic [10:0] CTL_MEMGO  = 11'b1_11111_000_00;
    localparam logic [10:0] CTL_MEMBR  = 11'b1_11111_111_01;

    initial begin
        clear_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Enter MEM_WAIT, then hold reset 3 cycles while a request is still presented
        MemRead_EX_MEM = 1'b1;
        step();
        #1 check("enter_wait_req", ctl(), CTL_FREEZE);
        reset = 1'b1;
        #1 check("reset_forces_off", ctl(), CTL_OFF);
        step(); step(); step();
        reset = 1'b0;
        clear_inputs();
        #1 check("post_reset_ctl", ctl(), CTL_RUN);
        check("post_reset_stall", stall_count, 0);
        check("post_reset_flush", flush_count, 0);
        check("post_reset_err", mem_error, 0);
        exp_stall = 0;
        exp_flush = 0;

        // Load-use via rt, then via rs, then a load into $zero
        step();
        ID_EX_MemRead = 1'b1; ID_EX_WriteReg = 5'd8; IF_ID_Rt = 5'd8; IF_ID_Rs = 5'd3;
        #1 check("lu_rt_ctl", ctl(), CTL_LU);
        step(); exp_stall++;
        check("lu_rt_stall", stall_count, exp_stall);
        IF_ID_Rt = 5'd4; IF_ID_Rs = 5'd8;
        #1 check("lu_rs_ctl", ctl(), CTL_LU);
        step(); exp_stall++;
        ID_EX_WriteReg = 5'd0; IF_ID_Rt = 5'd0; IF_ID_Rs = 5'd0;
        #1 check("lu_zero_ctl", ctl(), CTL_RUN);
        step();
        check("lu_zero_stall", stall_count, exp_stall);
        clear_inputs();

        // Redirects: BEQ taken, BNE not taken, JR, JAL
        BEQ_EX_MEM = 1'b1; Zero_EX_MEM = 1'b1;
        #1 check("beq_ctl", ctl(), CTL_BR);
        step(); exp_flush++;
        check("beq_flush_cnt", flush_count, exp_flush);
        clear_inputs();
        BNE_EX_MEM = 1'b1; Zero_EX_MEM = 1'b1;
        #1 check("bne_nt_ctl", ctl(), CTL_RUN);
        step();
        check("bne_nt_flush_cnt", flush_count, exp_flush);
        clear_inputs();
        JR_EX_MEM = 1'b1;
        #1 check("jr_ctl", ctl(), CTL_JR);
        step(); exp_flush++;
        clear_inputs();
        JAL_EX_MEM = 1'b1;
        #1 check("jal_ctl", ctl(), CTL_J);
        step(); exp_flush++;
        check("jal_flush_cnt", flush_count, exp_flush);
        clear_inputs();

        // Load-use coincident with a taken branch: redirect only
        ID_EX_MemRead = 1'b1; ID_EX_WriteReg = 5'd9; IF_ID_Rs = 5'd9;
        BEQ_EX_MEM = 1'b1; Zero_EX_MEM = 1'b1;
        #1 check("lu_br_ctl", ctl(), CTL_BR);
        step(); exp_flush++;
        check("lu_br_stall", stall_count, exp_stall);
        check("lu_br_flush", flush_count, exp_flush);
        clear_inputs();

        // Load with ready three cycles after the request
        MemRead_EX_MEM = 1'b1;
        #1 check("mem3_c0", ctl(), CTL_FREEZE);
        step();
        #1 check("mem3_c1", ctl(), CTL_FREEZE);
        step();
        #1 check("mem3_c2", ctl(), CTL_FREEZE);
        step();
        mem_ready = 1'b1;
        #1 check("mem3_ready", ctl(), CTL_MEMGO);
        step(); exp_stall += 3;
        clear_inputs();
        #1 check("mem3_after", ctl(), CTL_RUN);
        check("mem3_stall", stall_count, exp_stall);

        // Zero-wait store
        MemWrite_EX_MEM = 1'b1; mem_ready = 1'b1;
        #1 check("mem0_ctl", ctl(), CTL_MEMGO);
        step();
        check("mem0_stall", stall_count, exp_stall);
        clear_inputs();

        // Timeout: no ready ever
        MemRead_EX_MEM = 1'b1;
        #1 check("to_c0", ctl(), CTL_FREEZE);
        for (int k = 1; k <= 16; k++) begin
            step();
            #1;
            if (k < 16) begin
                check($sformatf("to_wait%0d", k), ctl(), CTL_FREEZE);
            end else begin
                check("to_release", ctl(), CTL_MEMGO);
                check("to_err_before", mem_error, 0);
            end
        end
        step(); exp_stall += 16;
        check("to_err", mem_error, 1);
        check("to_stall", stall_count, exp_stall);
        clear_inputs();
        #1 check("to_back_run", ctl(), CTL_RUN);
        step(); step();
        check("to_err_sticky", mem_error, 1);

        // Illegal take + mem_op: memory wins, redirect on the advancing cycle
        MemRead_EX_MEM = 1'b1; BEQ_EX_MEM = 1'b1; Zero_EX_MEM = 1'b1;
        #1 check("tm_c0", ctl(), CTL_FREEZE);
        step();
        mem_ready = 1'b1;
        #1 check("tm_ready", ctl(), CTL_MEMBR);
        step(); exp_stall++; exp_flush++;
        check("tm_stall", stall_count, exp_stall);
        check("tm_flush", flush_count, exp_flush);
        clear_inputs();

        // Saturation and short-timeout boundaries
        reset = 1'b1;
        step();
        reset = 1'b0;
        ID_EX_MemRead = 1'b1; ID_EX_WriteReg = 5'd5; IF_ID_Rt = 5'd5;
        for (int k = 0; k < 5; k++) step();
        check("sat_stall_wide", stall_count, 5);
        check("sat_stall_narrow", s_stall_count, 3);
        clear_inputs();
        J_EX_MEM = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("sat_flush_wide", flush_count, 5);
        check("sat_flush_narrow", s_flush_count, 3);
        clear_inputs();
        MemRead_EX_MEM = 1'b1;
        step();
        #1 check("short_wait1_en", s_PC_Enable, 0);
        step();
        #1 check("short_release_en", s_PC_Enable, 1);
        step();
        check("short_err", s_mem_error, 1);
        check("long_no_err", mem_error, 0);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB registers, and it selects the next-PC source.
- Handles load-use stalls, control transfers resolved in the MEM stage (branch/J/JAL/JR) and multi-cycle data-memory accesses through a req/ready handshake.
- Keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before abort and error flag
CNT_W, 16, width of the saturating stall and flush counters

Ports:
clk  in  1  system clock; all state updates on posedge clk
reset  in  1  synchronous, active-high reset
IF_ID_Rs  in  5  rs field of the instruction in ID
IF_ID_Rt  in  5  rt field of the instruction in ID
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_WriteReg  in  5  destination register of the instruction in EX
BEQ_EX_MEM, BNE_EX_MEM, Zero_EX_MEM, J_EX_MEM, JAL_EX_MEM, JR_EX_MEM  in  1 each  control from EX_MEM
MemRead_EX_MEM, MemWrite_EX_MEM  in  1 each  memory op in the MEM stage
mem_ready  in  1  data memory completes the access this cycle
mem_req  out  1  data memory access request
PC_Enable, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB  out  1 each  stage register enables
Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM  out  1 each  load a bubble (all controls 0) on the next clk
PCSrc  out  2  0 = PC+4, 1 = BranchAddress_EX_MEM, 2 = JumpAddress_EX_MEM, 3 = ReadData1_EX_MEM (JR)
mem_error  out  1  sticky flag: a memory access timed out
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of redirect events

Behaviour:
- Registered state: state in {RUN, MEM_WAIT}, wait counter (width clog2(MEM_TIMEOUT+1)), mem_error, stall_count, flush_count.
- All other outputs are combinational from state and inputs.
- Reset (reset = 1 at posedge):
  - state <= RUN; wait counter, mem_error and both counters <= 0.
  - While reset is high, outputs are forced to: all enables 0, all flushes 0, mem_req 0, PCSrc 0.
- Derived signals:
  - mem_op = MemRead_EX_MEM | MemWrite_EX_MEM.
  - take = (BEQ & Zero) | (BNE & ~Zero) | J | JAL | JR, all from EX_MEM.
  - load_use = ID_EX_MemRead & (ID_EX_WriteReg != 0) & (ID_EX_WriteReg == IF_ID_Rs | ID_EX_WriteReg == IF_ID_Rt).
- Default in RUN with no event: all enables 1, flushes 0, PCSrc 0.
- Priority: memory wait > redirect > load-use stall.
- Memory access:
  - In RUN, mem_op asserts mem_req in the same cycle.
  - If mem_ready is also 1, the access is zero-wait and the pipeline advances normally.
  - Otherwise: all five enables 0, state <= MEM_WAIT, wait counter <= 1.
- MEM_WAIT:
  - mem_req 1 and all enables 0 (full freeze); stall_count +1 per cycle.
  - On mem_ready: all enables 1 this cycle, state <= RUN.
  - If wait counter == MEM_TIMEOUT without mem_ready: mem_error <= 1, enables 1 (the result is dropped), state <= RUN.
  - Otherwise the wait counter increments.
- Redirect (RUN, take, access not stalled):
  - PCSrc selects the target: JR = 3; J or JAL = 2; branch = 1.
  - Flush_IF_ID, Flush_ID_EX and Flush_EX_MEM are all 1, all enables 1.
  - flush_count +1. Any load_use in the same cycle is ignored, because that instruction is being flushed.
- Load-use stall (RUN, no redirect, load_use):
  - PC_Enable = 0, Enable_IF_ID = 0, Flush_ID_EX = 1, remaining enables 1.
  - stall_count +1. Latency is one bubble: the dependent instruction leaves ID on the following cycle.
- take together with mem_op in EX_MEM is illegal per the ISA. If it occurs, the memory path wins and the redirect is issued on the cycle EX_MEM advances.
- Counters saturate at 2^CNT_W-1 and never wrap.
- mem_error clears only on reset.
- Reset asserted during MEM_WAIT aborts the access: mem_req drops the same cycle and state is RUN on the next cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - PCSrc constants PCSRC_SEQ = 0, PCSRC_BR = 1, PCSRC_J = 2, PCSRC_JR = 3;
  - the zero-register index 5'd0.
- One natural sub-module: hazard_detect, which is purely combinational and computes load_use and take.

Test Plan:
- Reset held 3 cycles mid MEM_WAIT, then released -> state RUN, all enables 1, counters 0, mem_error 0, mem_req 0.
- ID_EX_MemRead = 1, ID_EX_WriteReg = 8, IF_ID_Rt = 8 -> one cycle of PC_Enable = 0, Enable_IF_ID = 0, Flush_ID_EX = 1; stall_count = 1. Repeat with WriteReg = 0 -> no stall.
- BEQ = 1, Zero = 1 in EX_MEM -> PCSrc = 1, three flushes = 1, flush_count = 1. BNE = 1, Zero = 1 -> no redirect. JR = 1 -> PCSrc = 3.
- MemRead_EX_MEM = 1, mem_ready arriving 3 cycles later -> mem_req high for 4 cycles, enables 0 for 3 cycles then 1 on the ready cycle, stall_count = 3.
- mem_ready never asserted with MEM_TIMEOUT = 16 -> mem_error set after 16 wait cycles, state returns to RUN, mem_error stays 1.
- load_use and BEQ-taken in the same cycle -> redirect only, PCSrc = 1, PC_Enable = 1, stall_count unchanged.
